// File: rtl/store_buffer.sv
// store_buffer: circular store FIFO that drains to data memory and forwards buffered bytes to loads
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    input  logic [3:0]  st_be,
    input  logic [31:0] st_pc,
    output logic        st_ready,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_mem_rdata,
    output logic [31:0] ld_rdata,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_pc,
    input  logic        dm_ready,
    output logic [4:0]  count,
    output logic        empty
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    be_q   [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic [PW-1:0] idx;
    logic          enq, deq;
    logic          unused_ld;

    assign unused_ld = ^ld_addr[1:0];
    assign count     = count_q;
    assign empty     = count_q == 5'd0;
    assign st_ready  = count_q != 5'(DEPTH);
    assign dm_we     = !empty;
    assign dm_addr   = addr_q[rd_ptr_q];
    assign dm_wdata  = data_q[rd_ptr_q];
    assign dm_be     = be_q[rd_ptr_q];
    assign dm_pc     = pc_q[rd_ptr_q];
    assign enq       = st_valid && st_ready && st_be != 4'd0;
    assign deq       = dm_we && dm_ready;

    // next pointer and occupancy; power-of-two depth lets the pointers wrap naturally
    always_comb begin
        wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + 5'(enq) - 5'(deq);
    end

    // walk entries oldest to youngest so the youngest matching byte is the one that sticks
    always_comb begin
        ld_rdata = ld_mem_rdata;
        idx      = rd_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (5'(k) < count_q && addr_q[idx][31:2] == ld_addr[31:2])
                for (int b = 0; b < 4; b++)
                    if (be_q[idx][b]) ld_rdata[8*b +: 8] = data_q[idx][8*b +: 8];
        end
    end

    // pointer, count and entry storage; reset wipes everything including entry contents
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (enq) begin
                addr_q[wr_ptr_q] <= st_addr;
                data_q[wr_ptr_q] <= st_wdata;
                be_q[wr_ptr_q]   <= st_be;
                pc_q[wr_ptr_q]   <= st_pc;
            end
        end
    end

`ifndef SYNTHESIS
    // trace every retired store at the edge it leaves the buffer
    always_ff @(posedge clk) begin
        if (!reset && deq) $display("%d@%h: *%h <= %h", $time, dm_pc, dm_addr, dm_wdata);
    end
`endif
endmodule
